pkt_rx_sink: RTL and testbench
==============================

# pkt_rx_sink

Ejection-side endpoint of a NoC node: accepts flits from the local router output channel, buffers them per virtual channel, returns one credit per consumed flit, and reassembles them into packet descriptors presented on a valid/ready port. It is the consumer counterpart of the node's injection-side packet transmitter and closes the per-VC credit loop at the ejection port. It also checks protocol integrity and flags errors.

## Interface
- sx, default 0: X coordinate of this node; checked against head dstx.
- sy, default 0: Y coordinate of this node; checked against head dsty.
- NUM_VCS, CREDITS_PER_VC: router_pkg constants. Per-VC FIFO depth = CREDITS_PER_VC.

- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- flit_from_noc  in  channel_t  incoming flit; head.ftype==I means no flit.
- credits_to_noc  out  NUM_VCS x 1  one-cycle credit pulse per VC.
- rx_pkt_valid  out  1  descriptor valid.
- rx_pkt_ready  in  1  downstream accepts descriptor.
- rx_pkt_srcx, rx_pkt_srcy  out  head src widths  source of packet.
- rx_pkt_id  out  head pkt_id width  packet id.
- rx_pkt_flits  out  16  flit count of packet (HT = 1).
- rx_pkt_vcid  out  fvcid width  VC the packet used.
- pkts_rcvd  out  32  packets emitted, wraps.
- err_overflow, err_dst, err_seq  out  1 each  sticky error flags.

## Operation
- Write: any flit with ftype!=I written to FIFO[fvcid] at posedge. If FIFO full: flit dropped, err_overflow set, no credit ever returned for it.
- Per-VC reassembly state: IDLE, IN_PKT; regs srcx, srcy, pkt_id, expected payload index idx (16 bit).
- Pop selection: round-robin over VCs starting at rr_ptr; VC eligible if FIFO non-empty and (head flit is H or B) or (head flit is T/HT and output slot free, i.e. rx_pkt_valid==0 or rx_pkt_ready==1). At most one pop per cycle; after pop rr_ptr = (vc+1) % NUM_VCS.
- On pop, by ftype and state:
  - HT, IDLE: emit descriptor with flits=1; stay IDLE.
  - H, IDLE: latch src/pkt_id, idx=1, go IN_PKT.
  - B, IN_PKT: payload must equal idx else err_seq; idx++.
  - T, IN_PKT: payload check as B; emit descriptor with flits=idx+1; go IDLE.
  - H/HT while IN_PKT: err_seq; abandon old packet, process as from IDLE.
  - B/T while IDLE: err_seq; flit discarded.
  - H/HT head payload must be 0 else err_seq; dstx/dsty != sx/sy sets err_dst, packet still delivered.
- Every popped flit (including discarded ones) returns exactly one credit on its VC.
- pkts_rcvd increments on each descriptor emission.
- Error flags clear only on reset.

## Timing
- Reset: FIFOs empty, all VCs IDLE, rr_ptr=0, credits_to_noc all 0, rx_pkt_valid=0, descriptor fields 0, pkts_rcvd=0, all err flags 0. Reset mid-packet discards all buffered flits and partial state; no credits emitted for them.
- Flit arriving cycle N is poppable earliest cycle N+1 (zero bypass).
- Pop in cycle P: credits_to_noc[vc]=1 in cycle P+1 only (registered).
- Tail/HT popped in cycle P: rx_pkt_valid=1 with fields from cycle P+1; held stable until cycle with rx_pkt_ready=1; pop of another tail in that same cycle loads the new descriptor (back-to-back, no bubble).
- Simultaneous write and pop on the same VC with FIFO full: the pop frees a slot, the write is still an overflow (full evaluated before pop).
- Sustained throughput: one flit/cycle total across all VCs with rx_pkt_ready=1.

## Test plan
- HT to (sx,sy) on VC0, pkt_id=5 -> credits_to_noc[0] pulse 2 cycles after arrival, descriptor flits=1, id=5, pkts_rcvd=1, no errors.
- H,B,B,T (payload 0..3) on VC1 back-to-back -> 4 credit pulses on VC1, one descriptor flits=4, src matching head.
- Interleaved 3-flit packets on VC0 and VC1 alternating per cycle -> two correct descriptors, credits 3 per VC, round-robin pops alternate.
- rx_pkt_ready held 0 while two HT packets arrive -> first descriptor held stable; second HT stays in FIFO, no credit returned until ready=1, then both delivered in order.
- CREDITS_PER_VC+1 flits on VC0 with rx_pkt_ready=0 (tails blocked) -> err_overflow=1, extra flit dropped, total credits returned = CREDITS_PER_VC.
- B on idle VC, then HT with wrong dstx, then arst_n pulse mid H,B packet -> err_seq=1, err_dst=1 with descriptor delivered, after reset all outputs 0 and next packet reassembles cleanly.

Source files
------------

// File: rtl/pkt_rx_sink.sv
// NoC ejection endpoint: per-VC flit buffering, credit return, and packet
// reassembly into descriptors on a valid/ready port, with sticky error flags.
package router_pkg;
    localparam int NUM_VCS        = 2;
    localparam int CREDITS_PER_VC = 4;
    localparam int VC_W           = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int XY_W           = 4;
    localparam int ID_W           = 8;
    localparam int PAY_W          = 16;

    typedef enum logic [2:0] {
        FT_I  = 3'd0,
        FT_H  = 3'd1,
        FT_B  = 3'd2,
        FT_T  = 3'd3,
        FT_HT = 3'd4
    } ftype_t;

    typedef struct packed {
        ftype_t            ftype;
        logic [VC_W-1:0]   fvcid;
        logic [XY_W-1:0]   dstx;
        logic [XY_W-1:0]   dsty;
        logic [XY_W-1:0]   srcx;
        logic [XY_W-1:0]   srcy;
        logic [ID_W-1:0]   pkt_id;
    } head_t;

    typedef struct packed {
        head_t             head;
        logic [PAY_W-1:0]  payload;
    } channel_t;
endpackage

module pkt_rx_sink
    import router_pkg::*;
#(
    parameter int unsigned sx = 0,
    parameter int unsigned sy = 0
) (
    input  logic                clk,
    input  logic                arst_n,
    input  channel_t            flit_from_noc,
    output logic [NUM_VCS-1:0]  credits_to_noc,
    output logic                rx_pkt_valid,
    input  logic                rx_pkt_ready,
    output logic [XY_W-1:0]     rx_pkt_srcx,
    output logic [XY_W-1:0]     rx_pkt_srcy,
    output logic [ID_W-1:0]     rx_pkt_id,
    output logic [15:0]         rx_pkt_flits,
    output logic [VC_W-1:0]     rx_pkt_vcid,
    output logic [31:0]         pkts_rcvd,
    output logic                err_overflow,
    output logic                err_dst,
    output logic                err_seq
);
    localparam int PTR_W = (CREDITS_PER_VC > 1) ? $clog2(CREDITS_PER_VC) : 1;
    localparam int CNT_W = $clog2(CREDITS_PER_VC + 1);

    typedef enum logic {ST_IDLE, ST_IN_PKT} rx_state_t;

    channel_t          mem      [NUM_VCS][CREDITS_PER_VC];
    logic [PTR_W-1:0]  wr_ptr   [NUM_VCS];
    logic [PTR_W-1:0]  rd_ptr   [NUM_VCS];
    logic [CNT_W-1:0]  count    [NUM_VCS];
    rx_state_t         state    [NUM_VCS];
    logic [XY_W-1:0]   lat_srcx [NUM_VCS];
    logic [XY_W-1:0]   lat_srcy [NUM_VCS];
    logic [ID_W-1:0]   lat_id   [NUM_VCS];
    logic [15:0]       idx      [NUM_VCS];
    logic [VC_W-1:0]   rr_ptr;

    logic [NUM_VCS-1:0] wr_en, full, elig;
    logic               slot_free, overflow_p0;
    logic               pop_vld_p0;
    logic [VC_W-1:0]    pop_vc_p0, cand;
    channel_t           pop_flit_p0;
    ftype_t             hd_type;

    logic               emit_p0, latch_hdr_p0, seq_err_p0, dst_err_p0;
    rx_state_t          nxt_state_p0;
    logic [15:0]        nxt_idx_p0, e_flits_p0;
    logic [XY_W-1:0]    e_srcx_p0, e_srcy_p0;
    logic [ID_W-1:0]    e_id_p0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CREDITS_PER_VC - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [VC_W-1:0] vc_inc(input logic [VC_W-1:0] c);
        return (c == VC_W'(NUM_VCS - 1)) ? '0 : c + 1'b1;
    endfunction

    // Fullness is judged on the pre-pop count, so a write racing a pop on a full FIFO still overflows
    always_comb begin
        slot_free   = !rx_pkt_valid || rx_pkt_ready;
        hd_type     = FT_I;
        wr_en       = '0;
        full        = '0;
        elig        = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            full[v]  = (count[v] == CNT_W'(CREDITS_PER_VC));
            wr_en[v] = (flit_from_noc.head.ftype != FT_I) &&
                       (flit_from_noc.head.fvcid == VC_W'(v)) && !full[v];
            hd_type  = mem[v][rd_ptr[v]].head.ftype;
            elig[v]  = (count[v] != '0) &&
                       (!(hd_type == FT_T || hd_type == FT_HT) || slot_free);
        end
        overflow_p0 = (flit_from_noc.head.ftype != FT_I) && full[flit_from_noc.head.fvcid];

        pop_vld_p0 = 1'b0;
        pop_vc_p0  = rr_ptr;
        cand       = rr_ptr;
        for (int i = 0; i < NUM_VCS; i++) begin
            if (!pop_vld_p0 && elig[cand]) begin
                pop_vld_p0 = 1'b1;
                pop_vc_p0  = cand;
            end
            cand = vc_inc(cand);
        end
        pop_flit_p0 = mem[pop_vc_p0][rd_ptr[pop_vc_p0]];
    end

    always_comb begin
        emit_p0      = 1'b0;
        latch_hdr_p0 = 1'b0;
        seq_err_p0   = 1'b0;
        dst_err_p0   = 1'b0;
        nxt_state_p0 = state[pop_vc_p0];
        nxt_idx_p0   = idx[pop_vc_p0];
        e_flits_p0   = 16'd1;
        e_srcx_p0    = pop_flit_p0.head.srcx;
        e_srcy_p0    = pop_flit_p0.head.srcy;
        e_id_p0      = pop_flit_p0.head.pkt_id;
        if (pop_vld_p0) begin
            unique case (pop_flit_p0.head.ftype)
                FT_H, FT_HT: begin
                    seq_err_p0 = (state[pop_vc_p0] == ST_IN_PKT) || (pop_flit_p0.payload != '0);
                    dst_err_p0 = (pop_flit_p0.head.dstx != XY_W'(sx)) ||
                                 (pop_flit_p0.head.dsty != XY_W'(sy));
                    if (pop_flit_p0.head.ftype == FT_H) begin
                        latch_hdr_p0 = 1'b1;
                        nxt_state_p0 = ST_IN_PKT;
                        nxt_idx_p0   = 16'd1;
                    end else begin
                        emit_p0      = 1'b1;
                        nxt_state_p0 = ST_IDLE;
                    end
                end
                FT_B, FT_T: begin
                    if (state[pop_vc_p0] == ST_IN_PKT) begin
                        seq_err_p0 = (pop_flit_p0.payload != idx[pop_vc_p0]);
                        nxt_idx_p0 = idx[pop_vc_p0] + 16'd1;
                        if (pop_flit_p0.head.ftype == FT_T) begin
                            emit_p0      = 1'b1;
                            e_flits_p0   = idx[pop_vc_p0] + 16'd1;
                            e_srcx_p0    = lat_srcx[pop_vc_p0];
                            e_srcy_p0    = lat_srcy[pop_vc_p0];
                            e_id_p0      = lat_id[pop_vc_p0];
                            nxt_state_p0 = ST_IDLE;
                        end
                    end else begin
                        seq_err_p0 = 1'b1;
                    end
                end
                default: seq_err_p0 = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++)
            if (wr_en[v]) mem[v][wr_ptr[v]] <= flit_from_noc;
    end

    // Stage boundary: pop decision -> registered credit, descriptor and flags
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr[v]   <= '0;
                rd_ptr[v]   <= '0;
                count[v]    <= '0;
                state[v]    <= ST_IDLE;
                lat_srcx[v] <= '0;
                lat_srcy[v] <= '0;
                lat_id[v]   <= '0;
                idx[v]      <= '0;
            end
            rr_ptr         <= '0;
            credits_to_noc <= '0;
            rx_pkt_valid   <= 1'b0;
            rx_pkt_srcx    <= '0;
            rx_pkt_srcy    <= '0;
            rx_pkt_id      <= '0;
            rx_pkt_flits   <= '0;
            rx_pkt_vcid    <= '0;
            pkts_rcvd      <= '0;
            err_overflow   <= 1'b0;
            err_dst        <= 1'b0;
            err_seq        <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (wr_en[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop_vld_p0 && pop_vc_p0 == VC_W'(v)) rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                count[v] <= count[v] + CNT_W'(wr_en[v])
                            - CNT_W'(pop_vld_p0 && pop_vc_p0 == VC_W'(v));
                credits_to_noc[v] <= pop_vld_p0 && (pop_vc_p0 == VC_W'(v));
            end
            if (pop_vld_p0) begin
                rr_ptr           <= vc_inc(pop_vc_p0);
                state[pop_vc_p0] <= nxt_state_p0;
                idx[pop_vc_p0]   <= nxt_idx_p0;
                if (latch_hdr_p0) begin
                    lat_srcx[pop_vc_p0] <= pop_flit_p0.head.srcx;
                    lat_srcy[pop_vc_p0] <= pop_flit_p0.head.srcy;
                    lat_id[pop_vc_p0]   <= pop_flit_p0.head.pkt_id;
                end
            end
            err_overflow <= err_overflow | overflow_p0;
            err_dst      <= err_dst | dst_err_p0;
            err_seq      <= err_seq | seq_err_p0;
            if (emit_p0) begin
                rx_pkt_valid <= 1'b1;
                rx_pkt_srcx  <= e_srcx_p0;
                rx_pkt_srcy  <= e_srcy_p0;
                rx_pkt_id    <= e_id_p0;
                rx_pkt_flits <= e_flits_p0;
                rx_pkt_vcid  <= pop_flit_p0.head.fvcid;
                pkts_rcvd    <= pkts_rcvd + 32'd1;
            end else if (rx_pkt_ready) begin
                rx_pkt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pkt_rx_sink.sv
// Directed bench for pkt_rx_sink: credits, reassembly, backpressure,
// overflow, sequence/destination errors and mid-packet reset.
module tb_pkt_rx_sink;
    import router_pkg::*;

    localparam int SX = 2;
    localparam int SY = 3;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] flits;
        logic [3:0]  srcx;
        logic [3:0]  srcy;
        logic        vc;
    } desc_t;

    logic               clk = 1'b0;
    logic               arst_n;
    channel_t           flit;
    logic [NUM_VCS-1:0] credits;
    logic               valid, ready;
    logic [XY_W-1:0]    srcx, srcy;
    logic [ID_W-1:0]    id;
    logic [15:0]        flits;
    logic [VC_W-1:0]    vcid;
    logic [31:0]        pkts;
    logic               e_ovf, e_dst, e_seq;

    int    checks = 0;
    int    errors = 0;
    int    cred_cnt [NUM_VCS] = '{default: 0};
    desc_t dq [$];
    int    b0, b1;

    pkt_rx_sink #(.sx(SX), .sy(SY)) dut (
        .clk(clk), .arst_n(arst_n), .flit_from_noc(flit),
        .credits_to_noc(credits), .rx_pkt_valid(valid), .rx_pkt_ready(ready),
        .rx_pkt_srcx(srcx), .rx_pkt_srcy(srcy), .rx_pkt_id(id),
        .rx_pkt_flits(flits), .rx_pkt_vcid(vcid), .pkts_rcvd(pkts),
        .err_overflow(e_ovf), .err_dst(e_dst), .err_seq(e_seq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (arst_n) begin
            for (int v = 0; v < NUM_VCS; v++)
                if (credits[v]) cred_cnt[v] = cred_cnt[v] + 1;
            if (valid && ready) dq.push_back({id, flits, srcx, srcy, vcid});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic channel_t mk(input ftype_t t, input int vc, input int dx, input int dy,
                                    input int s_x, input int s_y, input int pid, input int pay);
        channel_t c;
        c.head.ftype  = t;
        c.head.fvcid  = VC_W'(vc);
        c.head.dstx   = XY_W'(dx);
        c.head.dsty   = XY_W'(dy);
        c.head.srcx   = XY_W'(s_x);
        c.head.srcy   = XY_W'(s_y);
        c.head.pkt_id = ID_W'(pid);
        c.payload     = PAY_W'(pay);
        return c;
    endfunction

    task automatic send(input channel_t f);
        flit = f;
        tick();
        flit = '0;
    endtask

    task automatic expect_desc(input string tag, input int pid, input int nfl,
                               input int s_x, input int s_y, input int vc);
        desc_t d, e;
        e = {8'(pid), 16'(nfl), 4'(s_x), 4'(s_y), 1'(vc)};
        chk({tag, "_present"}, 64'(dq.size() > 0), 64'd1);
        if (dq.size() > 0) begin
            d = dq.pop_front();
            chk(tag, 64'(d), 64'(e));
        end
    endtask

    initial begin
        arst_n = 1'b1;
        flit   = '0;
        ready  = 1'b0;
        #2 arst_n = 1'b0;
        tick(2);
        chk("rst_desc", {credits, valid, srcx, srcy, id, flits, vcid}, '0);
        chk("rst_pkts", pkts, 0);
        chk("rst_errs", {e_ovf, e_dst, e_seq}, 0);
        arst_n = 1'b1;
        ready  = 1'b1;
        tick();

        // single-flit packet
        send(mk(FT_HT, 0, SX, SY, 1, 1, 5, 0));
        tick();
        chk("t1_credit", credits, 2'b01);
        chk("t1_valid", valid, 1);
        chk("t1_fields", {id, flits, srcx, srcy, vcid}, {8'd5, 16'd1, 4'd1, 4'd1, 1'b0});
        tick();
        chk("t1_credit_off", credits, 0);
        chk("t1_pkts", pkts, 1);
        chk("t1_errs", {e_ovf, e_dst, e_seq}, 0);
        expect_desc("t1_desc", 5, 1, 1, 1, 0);

        // four-flit packet on VC1
        b1 = cred_cnt[1];
        send(mk(FT_H, 1, SX, SY, 4, 5, 7, 0));
        send(mk(FT_B, 1, 0, 0, 0, 0, 0, 1));
        send(mk(FT_B, 1, 0, 0, 0, 0, 0, 2));
        send(mk(FT_T, 1, 0, 0, 0, 0, 0, 3));
        tick(3);
        expect_desc("t2_desc", 7, 4, 4, 5, 1);
        chk("t2_credits", cred_cnt[1] - b1, 4);
        chk("t2_pkts", pkts, 2);

        // interleaved packets on VC0/VC1
        b0 = cred_cnt[0];
        b1 = cred_cnt[1];
        send(mk(FT_H, 0, SX, SY, 6, 7, 10, 0));
        send(mk(FT_H, 1, SX, SY, 8, 9, 11, 0));
        chk("t3_rr0", credits, 2'b01);
        send(mk(FT_B, 0, 0, 0, 0, 0, 0, 1));
        chk("t3_rr1", credits, 2'b10);
        send(mk(FT_B, 1, 0, 0, 0, 0, 0, 1));
        send(mk(FT_T, 0, 0, 0, 0, 0, 0, 2));
        send(mk(FT_T, 1, 0, 0, 0, 0, 0, 2));
        tick(3);
        expect_desc("t3_desc0", 10, 3, 6, 7, 0);
        expect_desc("t3_desc1", 11, 3, 8, 9, 1);
        chk("t3_cred0", cred_cnt[0] - b0, 3);
        chk("t3_cred1", cred_cnt[1] - b1, 3);
        chk("t3_errs", {e_ovf, e_dst, e_seq}, 0);

        // backpressure holds descriptor and blocks the second HT
        ready = 1'b0;
        b0 = cred_cnt[0];
        send(mk(FT_HT, 0, SX, SY, 1, 2, 20, 0));
        send(mk(FT_HT, 0, SX, SY, 1, 2, 21, 0));
        tick(3);
        chk("t4_hold_valid", valid, 1);
        chk("t4_hold_id", id, 20);
        chk("t4_blocked_cred", cred_cnt[0] - b0, 1);
        ready = 1'b1;
        tick();
        chk("t4_b2b", {valid, id}, {1'b1, 8'd21});
        tick();
        chk("t4_drained", valid, 0);
        expect_desc("t4_desc0", 20, 1, 1, 2, 0);
        expect_desc("t4_desc1", 21, 1, 1, 2, 0);
        chk("t4_cred", cred_cnt[0] - b0, 2);
        chk("t4_pkts", pkts, 6);

        // overflow: slot occupied by VC1 packet, VC0 fills and overflows
        ready = 1'b0;
        b0 = cred_cnt[0];
        send(mk(FT_HT, 1, SX, SY, 3, 3, 30, 0));
        for (int k = 0; k < CREDITS_PER_VC; k++)
            send(mk(FT_HT, 0, SX, SY, 3, 3, 31 + k, 0));
        chk("t5_full_no_ovf", e_ovf, 0);
        send(mk(FT_HT, 0, SX, SY, 3, 3, 31 + CREDITS_PER_VC, 0));
        chk("t5_ovf", e_ovf, 1);
        chk("t5_no_cred", cred_cnt[0] - b0, 0);
        ready = 1'b1;
        tick(12);
        expect_desc("t5_desc30", 30, 1, 3, 3, 1);
        for (int k = 0; k < CREDITS_PER_VC; k++)
            expect_desc("t5_desc_vc0", 31 + k, 1, 3, 3, 0);
        chk("t5_dropped", dq.size(), 0);
        chk("t5_cred", cred_cnt[0] - b0, CREDITS_PER_VC);
        chk("t5_pkts", pkts, 11);

        // sequence error, destination error, mid-packet reset
        b0 = cred_cnt[0];
        send(mk(FT_B, 0, 0, 0, 0, 0, 0, 0));
        tick(2);
        chk("t6_seq", {e_seq, e_dst}, 2'b10);
        chk("t6_seq_cred", cred_cnt[0] - b0, 1);
        chk("t6_seq_nodesc", dq.size(), 0);
        send(mk(FT_HT, 0, 9, SY, 3, 3, 40, 0));
        tick(2);
        chk("t6_dst", e_dst, 1);
        expect_desc("t6_desc40", 40, 1, 3, 3, 0);
        send(mk(FT_H, 1, SX, SY, 5, 5, 41, 0));
        send(mk(FT_B, 1, 0, 0, 0, 0, 0, 1));
        arst_n = 1'b0;
        #2;
        chk("t6_rst_desc", {credits, valid, srcx, srcy, id, flits, vcid}, '0);
        chk("t6_rst_pkts", pkts, 0);
        chk("t6_rst_errs", {e_ovf, e_dst, e_seq}, 0);
        tick();
        arst_n = 1'b1;
        dq.delete();
        b1 = cred_cnt[1];
        tick(2);
        chk("t6_no_stale_cred", cred_cnt[1] - b1, 0);
        send(mk(FT_H, 1, SX, SY, 7, 6, 42, 0));
        send(mk(FT_B, 1, 0, 0, 0, 0, 0, 1));
        send(mk(FT_T, 1, 0, 0, 0, 0, 0, 2));
        tick(3);
        expect_desc("t6_desc42", 42, 3, 7, 6, 1);
        chk("t6_post_pkts", pkts, 1);
        chk("t6_post_errs", {e_ovf, e_dst, e_seq}, 0);
        chk("t6_post_cred", cred_cnt[1] - b1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
